// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the sequential ALU.
//                Holds the opcode enum, the FSM state enum and the default
//                data-path / command widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_def_w     = 8;
    localparam int c_def_cmd_w = 4;

    typedef enum logic [c_def_cmd_w-1:0] {
        OP_NOP  = 4'd0,
        OP_XOR  = 4'd1,
        OP_NZ   = 4'd2,
        OP_ADD  = 4'd3,
        OP_LSH  = 4'd4,
        OP_RSH  = 4'd5,
        OP_PASB = 4'd6,
        OP_PASA = 4'd7,
        OP_PARI = 4'd8
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational single-cycle ALU operations plus result flags.
//                Shift opcodes are not handled here (result 0); the owning
//                sequencer runs them bit-serially.
//  Ports       : i_cmd, i_a, i_b, i_ci   - operation and operands
//                o_res, o_co              - single-cycle result and carry
//                i_flag_src               - value whose flags are wanted
//                o_pari, o_zero           - parity / zero of i_flag_src
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int W     = c_def_w,
    parameter int CMD_W = c_def_cmd_w
) (
    input  logic [CMD_W-1:0] i_cmd,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic             i_ci,
    input  logic [W-1:0]     i_flag_src,
    output logic [W-1:0]     o_res,
    output logic             o_co,
    output logic             o_pari,
    output logic             o_zero
);

    logic [W:0] w_sum;

    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
        o_res = '0;
        o_co  = 1'b0;
        case (i_cmd)
            CMD_W'(OP_XOR):  o_res = i_a ^ i_b;
            CMD_W'(OP_NZ):   o_res = {{(W-1){1'b0}}, |i_a};
            CMD_W'(OP_ADD): begin
                o_res = w_sum[W-1:0];
                o_co  = w_sum[W];
            end
            CMD_W'(OP_PASB): o_res = i_b;
            CMD_W'(OP_PASA): o_res = i_a;
            CMD_W'(OP_PARI): o_res = {{(W-1){1'b0}}, ^i_b};
            default: ;
        endcase
    end

    assign o_pari = ^i_flag_src;
    assign o_zero = (i_flag_src == '0);

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU with valid/ready handshakes. Single-cycle ops
//                come from alu_core; shifts run one bit per cycle in the
//                result register itself.
//  Ports       : clk, reset (sync, active high)
//                alu_cmd, inA, inB, sc_i, in_valid / in_ready  - request
//                rslt, sc_o, pari, zero, out_valid / out_ready - response
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int W     = c_def_w,
    parameter int CMD_W = c_def_cmd_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [W-1:0]     inA,
    input  logic [W-1:0]     inB,
    input  logic             sc_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     rslt,
    output logic             sc_o,
    output logic             pari,
    output logic             zero
);

    localparam int              c_cnt_w = $clog2(W + 1);
    localparam logic [W-1:0]    c_w_val = W[W-1:0];
    localparam logic [c_cnt_w-1:0] c_cnt_max = W[c_cnt_w-1:0];

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_left;
    logic [W-1:0]         r_rslt;
    logic                 r_sc;
    logic                 r_pari;
    logic                 r_zero;

    logic                 w_is_lsh;
    logic                 w_is_shift;
    logic [c_cnt_w-1:0]   w_cnt_init;
    logic [W-1:0]         w_shifted;
    logic                 w_shift_out;
    logic [W-1:0]         w_next_rslt;
    logic [W-1:0]         w_core_res;
    logic                 w_core_co;
    logic                 w_pari;
    logic                 w_zero;

    assign w_is_lsh   = (alu_cmd == CMD_W'(OP_LSH));
    assign w_is_shift = w_is_lsh || (alu_cmd == CMD_W'(OP_RSH));
    // Shift distances of W or more saturate: the register is all zero by then.
    assign w_cnt_init = (inA >= c_w_val) ? c_cnt_max : inA[c_cnt_w-1:0];

    assign w_shifted   = r_left ? {r_rslt[W-2:0], 1'b0} : {1'b0, r_rslt[W-1:1]};
    assign w_shift_out = r_left ? r_rslt[W-1] : r_rslt[0];

    // Value about to be written into r_rslt; its flags are registered with it
    // so pari/zero always describe the registered result.
    always_comb begin
        w_next_rslt = r_rslt;
        case (r_state)
            ST_IDLE:  w_next_rslt = w_is_shift ? inB : w_core_res;
            ST_SHIFT: w_next_rslt = w_shifted;
            default:  ;
        endcase
    end

    alu_core #(
        .W     (W),
        .CMD_W (CMD_W)
    ) u_core (
        .i_cmd      (alu_cmd),
        .i_a        (inA),
        .i_b        (inB),
        .i_ci       (sc_i),
        .i_flag_src (w_next_rslt),
        .o_res      (w_core_res),
        .o_co       (w_core_co),
        .o_pari     (w_pari),
        .o_zero     (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_is_shift && (w_cnt_init != '0)) w_state_nxt = ST_SHIFT;
                    else                                  w_state_nxt = ST_DONE;
                end
            end
            ST_SHIFT: if (r_cnt == c_cnt_w'(1)) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs; gated by reset so nothing is signalled while it is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!reset) begin
            in_ready  = (r_state == ST_IDLE);
            out_valid = (r_state == ST_DONE);
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_left <= 1'b0;
            r_rslt <= '0;
            r_sc   <= 1'b0;
            r_pari <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_left <= w_is_lsh;
                        r_cnt  <= w_cnt_init;
                        r_rslt <= w_next_rslt;
                        r_sc   <= w_is_shift ? 1'b0 : w_core_co;
                        r_pari <= w_pari;
                        r_zero <= w_zero;
                    end
                end
                ST_SHIFT: begin
                    r_rslt <= w_next_rslt;
                    r_sc   <= w_shift_out;
                    r_cnt  <= r_cnt - c_cnt_w'(1);
                    r_pari <= w_pari;
                    r_zero <= w_zero;
                end
                default: ;
            endcase
        end
    end

    assign rslt = r_rslt;
    assign sc_o = r_sc;
    assign pari = r_pari;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (W=8, CMD_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_cmd;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       sc_i;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       zero;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_alu #(.W(8), .CMD_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_cmd   (alu_cmd),
        .inA       (inA),
        .inB       (inB),
        .sc_i      (sc_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rslt      (rslt),
        .sc_o      (sc_o),
        .pari      (pari),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble operands afterwards, and check the number of
    // cycles from accept until out_valid.
    task automatic do_op(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input int exp_lat);
        int lat;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        alu_cmd  = cmd;
        inA      = a;
        inB      = b;
        sc_i     = ci;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_cmd  = 4'h1;
        inA      = 8'hC3;
        inB      = 8'h3C;
        sc_i     = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        reset     = 1'b1;
        alu_cmd   = '0;
        inA       = '0;
        inB       = '0;
        sc_i      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_rslt", rslt, 8'h00);
        chk("rst_sc_o", sc_o, 1'b0);
        chk("rst_pari", pari, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // ADD 0xF0 + 0x20 + 1 = 0x111
        do_op("add", 4'd3, 8'hF0, 8'h20, 1'b1, 1);
        chk("add_rslt", rslt, 8'h11);
        chk("add_sc_o", sc_o, 1'b1);
        chk("add_zero", zero, 1'b0);
        chk("add_pari", pari, 1'b0);
        tick();

        // LSH 0xB1 by 3 -> 0x88, last bit out is bit 5 = 1
        do_op("lsh", 4'd4, 8'd3, 8'hB1, 1'b0, 4);
        chk("lsh_rslt", rslt, 8'h88);
        chk("lsh_sc_o", sc_o, 1'b1);
        chk("lsh_pari", pari, 1'b0);
        tick();

        // RSH 0xFF by 200 saturates at 8 shifts
        do_op("rsh", 4'd5, 8'd200, 8'hFF, 1'b0, 9);
        chk("rsh_rslt", rslt, 8'h00);
        chk("rsh_zero", zero, 1'b1);
        chk("rsh_sc_o", sc_o, 1'b1);
        tick();

        // Shift by 0 passes inB straight through
        do_op("lsh0", 4'd4, 8'd0, 8'h3C, 1'b1, 1);
        chk("lsh0_rslt", rslt, 8'h3C);
        chk("lsh0_sc_o", sc_o, 1'b0);
        tick();

        // XOR with back-pressure and an ignored request
        out_ready = 1'b0;
        do_op("xor", 4'd1, 8'h5A, 8'h5A, 1'b0, 1);
        alu_cmd  = 4'd7;
        inA      = 8'h77;
        inB      = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rslt", rslt, 8'h00);
            chk("hold_zero", zero, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("xor_back_idle", in_ready, 1'b1);
        chk("xor_no_queue_rslt", rslt, 8'h00);
        tick();
        chk("xor_no_queue_valid", out_valid, 1'b0);

        // Reset on the 2nd SHIFT cycle of LSH by 6
        chk("rs_in_ready", in_ready, 1'b1);
        alu_cmd  = 4'd4;
        inA      = 8'd6;
        inB      = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rs_shift1_valid", out_valid, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("rs_during_in_ready", in_ready, 1'b0);
        chk("rs_during_out_valid", out_valid, 1'b0);
        tick();
        chk("rs_rslt", rslt, 8'h00);
        chk("rs_sc_o", sc_o, 1'b0);
        chk("rs_pari", pari, 1'b0);
        chk("rs_zero", zero, 1'b0);
        reset = 1'b0;
        #1;
        chk("rs_rel_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("rs_no_valid", out_valid, 1'b0);
            tick();
        end

        // Unused opcode
        do_op("op_f", 4'hF, 8'hFF, 8'hFF, 1'b1, 1);
        chk("op_f_rslt", rslt, 8'h00);
        chk("op_f_sc_o", sc_o, 1'b0);
        chk("op_f_zero", zero, 1'b1);
        chk("op_f_pari", pari, 1'b0);
        tick();

        // NZ
        do_op("nz0", 4'd2, 8'h00, 8'hAB, 1'b0, 1);
        chk("nz0_rslt", rslt, 8'h00);
        tick();
        do_op("nz5", 4'd2, 8'h05, 8'h00, 1'b0, 1);
        chk("nz5_rslt", rslt, 8'h01);
        tick();

        // PARI of 0x07
        do_op("pari", 4'd8, 8'hFF, 8'h07, 1'b0, 1);
        chk("pari_rslt", rslt, 8'h01);
        chk("pari_flag", pari, 1'b1);
        chk("pari_zero", zero, 1'b0);
        tick();

        // PASSA / PASSB
        do_op("pasa", 4'd7, 8'h96, 8'h11, 1'b1, 1);
        chk("pasa_rslt", rslt, 8'h96);
        chk("pasa_sc_o", sc_o, 1'b0);
        tick();
        do_op("pasb", 4'd6, 8'h96, 8'h23, 1'b0, 1);
        chk("pasb_rslt", rslt, 8'h23);
        chk("pasb_pari", pari, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the data path width in bits (W >= 2).
REQ-002 The module SHALL have parameter CMD_W, default 4, giving the command field width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port alu_cmd, input, CMD_W bits: operation code, sampled on accept.
REQ-006 The module SHALL have ports inA and inB, input, W bits each: operands, sampled on accept.
REQ-007 The module SHALL have port sc_i, input, 1 bit: carry in for ADD, sampled on accept.
REQ-008 The module SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit); a request is accepted on a cycle where both are high.
REQ-009 The module SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit); a result is consumed on a cycle where both are high.
REQ-010 The module SHALL have port rslt, output, W bits: the result, registered.
REQ-011 The module SHALL have port sc_o, output, 1 bit: carry or shift-out flag, registered.
REQ-012 The module SHALL have ports pari (output, 1 bit, XOR reduction of rslt) and zero (output, 1 bit, high when rslt == 0), both registered.

Function
REQ-013 Opcodes SHALL be: 1 XOR (inA^inB), 2 NZ (rslt = 1 if inA != 0, else 0), 3 ADD (inA+inB+sc_i, sc_o = carry out), 4 LSH (inB << inA), 5 RSH (inB >> inA), 6 PASSB (inB), 7 PASSA (inA), 8 PARI (rslt = ^inB in bit 0, upper bits 0).
REQ-014 Opcodes 0 and 9 through 2^CMD_W-1 SHALL produce rslt = 0 and sc_o = 0, with pari and zero computed normally.
REQ-015 sc_o SHALL be 0 for every operation except ADD and the shifts.
REQ-016 pari and zero SHALL always be derived from the final registered rslt value.
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in DONE.
REQ-018 In IDLE, on accept, a non-shift operation SHALL go to DONE with its result registered, so out_valid rises 1 cycle after accept.
REQ-019 In IDLE, on accept, a shift SHALL load inB and set count = min(inA, W); count 0 SHALL go straight to DONE with rslt = inB and sc_o = 0, otherwise the FSM SHALL go to SHIFT.
REQ-020 In SHIFT, each cycle SHALL shift the working register by 1 bit with zero fill, capture the bit shifted out into sc_o, and decrement count; when count reaches 0 the FSM SHALL enter DONE.
REQ-021 For a shift by k, out_valid SHALL rise min(k, W)+1 cycles after accept; any shift with k >= W SHALL give rslt = 0, with sc_o equal to the last bit shifted out.
REQ-022 In DONE, rslt, sc_o, pari and zero SHALL hold stable until out_ready is high, and the FSM SHALL then return to IDLE on the next cycle.
REQ-023 in_valid while not in IDLE SHALL be ignored, with no queuing; operand changes after accept SHALL not affect the result in flight.
REQ-024 The maximum throughput SHALL be one operation every 2 cycles (accept, then DONE with out_ready held high).

Reset
REQ-025 While reset is high, the FSM SHALL go to IDLE on the next clk edge and rslt, sc_o, pari and zero SHALL be 0.
REQ-026 While reset is high, in_ready SHALL be 0 and out_valid SHALL be 0; in_ready SHALL rise on the first cycle after reset is released.
REQ-027 A reset during SHIFT or DONE SHALL discard the operation in flight without producing an out_valid pulse.

Structure
REQ-028 A shared package alu_pkg SHALL hold the opcode enum (CMD_W wide), the FSM state enum, and the default constants W=8 and CMD_W=4.
REQ-029 A single combinational sub-module alu_core SHALL compute the single-cycle operations and the result flags; seq_alu SHALL own the FSM, the shift datapath and the handshake.

Verification
REQ-030 The bench SHALL check: W=8, ADD inA=0xF0, inB=0x20, sc_i=1 -> 1 cycle later rslt=0x11, sc_o=1, zero=0, pari=0.
REQ-031 The bench SHALL check: LSH inA=3, inB=0xB1 -> out_valid 4 cycles after accept, rslt=0x88, sc_o=1 (bit 5 of 0xB1), pari=0.
REQ-032 The bench SHALL check: RSH inA=200, inB=0xFF -> out_valid 9 cycles after accept, rslt=0x00, zero=1, sc_o=1.
REQ-033 The bench SHALL check: XOR 0x5A^0x5A with out_ready low for 5 cycles -> rslt=0 and zero=1 held stable, in_ready=0 throughout, and a new in_valid ignored.
REQ-034 The bench SHALL check: reset asserted on the 2nd cycle of SHIFT for LSH inA=6 -> no out_valid pulse, all outputs 0, in_ready=1 on the first cycle after reset is released.
REQ-035 The bench SHALL check: opcode 0xF with inA=0xFF, inB=0xFF -> rslt=0, sc_o=0, zero=1, pari=0; NZ with inA=0 -> rslt=0; PARI with inB=0x07 -> rslt=0x01.
